// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared types and widths for the fetch-side PC logic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;
  localparam int          c_PC_W           = 32;
  localparam int          c_IMM_W          = 16;
  localparam int          c_JIDX_W         = 26;
  localparam logic [31:0] c_RESET_PC_DFLT  = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pcseq_state_e;
endpackage

`default_nettype wire

// File: rtl/pc_sequencer_branch_target.sv
// ============================================================================
// Module  : branch_target
// Brief   : Branch target = pc4 + (sign_ext(imm) << 2), carry discarded.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_target
  import cpu_pkg::*;
(
  input  logic [c_PC_W-1:0]  pc4_i,
  input  logic [c_IMM_W-1:0] imm_i,
  output logic [c_PC_W-1:0]  target_o
);
  logic [c_PC_W-1:0] w_offset;

  assign w_offset = {{(c_PC_W-c_IMM_W-2){imm_i[c_IMM_W-1]}}, imm_i, 2'b00};
  assign target_o = pc4_i + w_offset;
endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module  : pc_sequencer
// Brief   : Fetch PC register with branch/jump redirect, stall-pending FSM,
//           squash lines and taken-redirect counter.
//           Option macro: BRANCH_DELAY_SLOT_EN (delay-slot squash behaviour).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_RESET_PC_DFLT,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 br_valid,
  input  logic                 br_taken,
  input  logic [31:0]          br_pc4,
  input  logic [15:0]          br_imm,
  input  logic                 jmp_valid,
  input  logic [3:0]           jmp_pc4_hi,
  input  logic [25:0]          jmp_index,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic [CNT_W-1:0]     redirect_cnt
);
  pcseq_state_e      state_q;
  logic [31:0]       pc_q;
  logic [31:0]       pend_pc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              w_br_req;
  logic              w_redirect;
  logic [31:0]       w_br_target;
  logic [31:0]       w_jmp_target;
  logic [31:0]       w_target;

  branch_target u_branch_target (
    .pc4_i    (br_pc4),
    .imm_i    (br_imm),
    .target_o (w_br_target)
  );

  // Branch is the older instruction, so it beats a simultaneous jump.
  assign w_br_req     = br_valid & br_taken;
  assign w_redirect   = w_br_req | jmp_valid;
  assign w_jmp_target = {jmp_pc4_hi, jmp_index, 2'b00};
  assign w_target     = w_br_req ? w_br_target : w_jmp_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_redirect) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (stall) begin
              pend_pc_q <= w_target;
              state_q   <= ST_PEND;
            end else begin
              pc_q <= w_target;
            end
          end else if (!stall) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        ST_PEND: begin
          // A younger redirect replaces the held target without recounting.
          if (stall) begin
            if (w_redirect) pend_pc_q <= w_target;
          end else begin
            pc_q    <= w_redirect ? w_target : pend_pc_q;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_cnt = cnt_q;

`ifdef BRANCH_DELAY_SLOT_EN
  assign flush_ifid = 1'b0;
  assign flush_idex = ~rst & w_br_req;
`else
  assign flush_ifid = ~rst & w_redirect;
  assign flush_idex = ~rst & w_br_req;
`endif
endmodule

`default_nettype wire
